ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/ex_mem_reg.sv | 154 +++++++++++++++
 tb/tb_ex_mem_reg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: word/register widths plus the EX/MEM holding entry and its FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } exmem_state_t;

  typedef struct packed {
    word_t    aluout;
    logic     zero;
    logic     negative;
    logic     overflow;
    word_t    pc;
    regbits_t rd;
    logic     regwrite;
    logic     dren;
    logic     dwen;
    word_t    store;
  } exmem_entry_t;

  // An entry with its side-effecting controls removed; used for squashed or vacated slots.
  function automatic exmem_entry_t exmem_strip_ctrl(exmem_entry_t e);
    exmem_entry_t r;
    r          = e;
    r.regwrite = 1'b0;
    r.dren     = 1'b0;
    r.dwen     = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: two-entry skid buffer with a registered ex_ready.
// Optional overflow trap capture enabled by defining OVERFLOW_TRAP_EN.
module ex_mem_reg
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_EPC = 32'h0
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     flush,
  input  logic     ex_valid,
  output logic     ex_ready,
  input  word_t    ex_aluout,
  input  logic     ex_zero,
  input  logic     ex_negative,
  input  logic     ex_overflow,
  input  logic     ex_signed_op,
  input  word_t    ex_pc,
  input  regbits_t ex_rd,
  input  logic     ex_regwrite,
  input  logic     ex_dren,
  input  logic     ex_dwen,
  input  word_t    ex_store,
  output logic     mem_valid,
  input  logic     mem_ready,
  output word_t    mem_aluout,
  output logic     mem_zero,
  output logic     mem_negative,
  output logic     mem_overflow,
  output word_t    mem_pc,
  output regbits_t mem_rd,
  output logic     mem_regwrite,
  output logic     mem_dren,
  output logic     mem_dwen,
  output word_t    mem_store,
  output logic     exc_valid,
  output word_t    exc_epc,
  input  logic     exc_ack
);

  exmem_state_t state;
  exmem_entry_t main_q;
  exmem_entry_t skid_q;
  exmem_entry_t in_entry;
  logic         accept;
  logic         deliver;

  assign accept  = ex_valid && ex_ready;
  assign deliver = mem_valid && mem_ready;

`ifdef OVERFLOW_TRAP_EN
  logic trap;

  always_comb begin
    in_entry = '{aluout: ex_aluout, zero: ex_zero, negative: ex_negative,
                 overflow: ex_overflow, pc: ex_pc, rd: ex_rd,
                 regwrite: ex_regwrite, dren: ex_dren, dwen: ex_dwen,
                 store: ex_store};
    if (ex_overflow && ex_signed_op) begin
      in_entry = exmem_strip_ctrl(in_entry);
    end
    trap = accept && ex_overflow && ex_signed_op && !flush;
  end

  // A trap arriving with the ack replaces the acknowledged one; otherwise the first EPC sticks.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exc_valid <= 1'b0;
      exc_epc   <= RESET_EPC;
    end else if (trap && (!exc_valid || exc_ack)) begin
      exc_valid <= 1'b1;
      exc_epc   <= ex_pc;
    end else if (exc_ack) begin
      exc_valid <= 1'b0;
    end
  end
`else
  logic unused_trap_inputs;

  always_comb begin
    in_entry = '{aluout: ex_aluout, zero: ex_zero, negative: ex_negative,
                 overflow: ex_overflow, pc: ex_pc, rd: ex_rd,
                 regwrite: ex_regwrite, dren: ex_dren, dwen: ex_dwen,
                 store: ex_store};
  end

  assign unused_trap_inputs = ^{exc_ack, ex_signed_op};
  assign exc_valid          = 1'b0;
  assign exc_epc            = RESET_EPC;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      mem_valid <= 1'b0;
      ex_ready  <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      main_q    <= exmem_strip_ctrl(main_q);
      mem_valid <= 1'b0;
      ex_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          ex_ready <= 1'b1;
          if (accept) begin
            main_q    <= in_entry;
            mem_valid <= 1'b1;
            state     <= FULL;
          end
        end
        FULL: begin
          if (accept && deliver) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q   <= in_entry;
            ex_ready <= 1'b0;
            state    <= SKID;
          end else if (deliver) begin
            main_q    <= exmem_strip_ctrl(main_q);
            mem_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        SKID: begin
          if (deliver) begin
            main_q   <= skid_q;
            ex_ready <= 1'b1;
            state    <= FULL;
          end
        end
        default: begin
          state     <= EMPTY;
          mem_valid <= 1'b0;
          ex_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_aluout   = main_q.aluout;
  assign mem_zero     = main_q.zero;
  assign mem_negative = main_q.negative;
  assign mem_overflow = main_q.overflow;
  assign mem_pc       = main_q.pc;
  assign mem_rd       = main_q.rd;
  assign mem_regwrite = main_q.regwrite;
  assign mem_dren     = main_q.dren;
  assign mem_dwen     = main_q.dwen;
  assign mem_store    = main_q.store;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: queue-based reference model plus directed scenarios.
module tb_ex_mem_reg;

`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] RST_EPC = 32'h0;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_aluout = '0;
  logic        ex_zero = 1'b0, ex_negative = 1'b0, ex_overflow = 1'b0, ex_signed_op = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_regwrite = 1'b0, ex_dren = 1'b0, ex_dwen = 1'b0;
  logic [31:0] ex_store = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_aluout, mem_pc, mem_store;
  logic        mem_zero, mem_negative, mem_overflow;
  logic [4:0]  mem_rd;
  logic        mem_regwrite, mem_dren, mem_dwen;
  logic        exc_valid;
  logic [31:0] exc_epc;
  logic        exc_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  ex_mem_reg #(.RESET_EPC(RST_EPC)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluout(ex_aluout), .ex_zero(ex_zero), .ex_negative(ex_negative),
    .ex_overflow(ex_overflow), .ex_signed_op(ex_signed_op), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
    .ex_store(ex_store),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_aluout(mem_aluout), .mem_zero(mem_zero), .mem_negative(mem_negative),
    .mem_overflow(mem_overflow), .mem_pc(mem_pc), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
    .mem_store(mem_store),
    .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_ack(exc_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the register is a FIFO of at most two in-flight results.
  typedef struct {
    logic [31:0] aluout, pc, store;
    logic [4:0]  rd;
    logic [2:0]  flags;
    logic [2:0]  ctl;
  } item_t;

  item_t       q[$];
  bit          m_ready;
  bit          m_exc;
  logic [31:0] m_epc;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q.delete();
      m_ready = 1'b0;
      m_exc   = 1'b0;
      m_epc   = RST_EPC;
    end else begin
      bit    acc, del, ovf_trap;
      item_t it;
      acc      = ex_valid && m_ready;
      del      = (q.size() > 0) && mem_ready;
      ovf_trap = TRAP_EN && ex_overflow && ex_signed_op;
      it.aluout = ex_aluout;
      it.pc     = ex_pc;
      it.store  = ex_store;
      it.rd     = ex_rd;
      it.flags  = {ex_zero, ex_negative, ex_overflow};
      it.ctl    = ovf_trap ? 3'b000 : {ex_regwrite, ex_dren, ex_dwen};
      if (flush) begin
        q.delete();
      end else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(it);
      end
      m_ready = (q.size() < 2);
      if (m_exc && exc_ack) m_exc = 1'b0;
      if (acc && ovf_trap && !flush && !m_exc) begin
        m_exc = 1'b1;
        m_epc = ex_pc;
      end
    end
  end

  always @(negedge CLK) begin
    chk("mem_valid", mem_valid, q.size() > 0);
    chk("ex_ready", ex_ready, m_ready);
    chk("exc_valid", exc_valid, m_exc);
    chk("exc_epc", exc_epc, m_epc);
    if (q.size() > 0) begin
      chk("mem_data", {mem_aluout, mem_pc, mem_store, mem_rd},
          {q[0].aluout, q[0].pc, q[0].store, q[0].rd});
      chk("mem_flags", {mem_zero, mem_negative, mem_overflow}, q[0].flags);
      chk("mem_ctl", {mem_regwrite, mem_dren, mem_dwen}, q[0].ctl);
    end else begin
      chk("idle_ctl", {mem_regwrite, mem_dren, mem_dwen}, 3'b000);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; ex_valid = 1'b0; ex_overflow = 1'b0; ex_signed_op = 1'b0;
    ex_regwrite = 1'b0; ex_dren = 1'b0; ex_dwen = 1'b0; exc_ack = 1'b0;
  endtask

  task automatic push(input logic [31:0] val);
    ex_valid = 1'b1; ex_aluout = val; ex_pc = val + 32'h100;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #13;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_word", {mem_aluout, mem_pc, mem_store, mem_rd}, '0);
    chk("rst_exc", {exc_valid, exc_epc}, {1'b0, RST_EPC});
    @(posedge CLK); #1; nRST = 1'b1;
    tick();
    chk("rel_ex_ready", ex_ready, 1'b1);

    // Single transfer, one-cycle latency
    mem_ready = 1'b1; ex_valid = 1'b1; ex_aluout = 32'h0000_0010;
    tick();
    ex_valid = 1'b0;
    chk("lat_valid", mem_valid, 1'b1);
    chk("lat_alu", mem_aluout, 32'h10);
    chk("lat_ready", ex_ready, 1'b1);
    tick();
    chk("lat_drain", mem_valid, 1'b0);

    // Fill to SKID, then drain in order
    mem_ready = 1'b0;
    push(32'hA); push(32'hB);
    ex_valid = 1'b0;
    chk("skid_ready", ex_ready, 1'b0);
    chk("skid_head", mem_aluout, 32'hA);
    tick();
    chk("skid_stable", mem_aluout, 32'hA);
    mem_ready = 1'b1;
    tick();
    chk("order_b", mem_aluout, 32'hB);
    chk("order_ready", ex_ready, 1'b1);
    tick();
    chk("order_empty", mem_valid, 1'b0);

    // Flush from SKID with an offered entry
    mem_ready = 1'b0;
    push(32'hA1); push(32'hB1);
    flush = 1'b1; ex_valid = 1'b1; ex_aluout = 32'hC1; ex_regwrite = 1'b1;
    tick();
    idle_inputs();
    chk("flush_valid", mem_valid, 1'b0);
    chk("flush_ready", ex_ready, 1'b1);
    mem_ready = 1'b1;
    tick();
    chk("flush_nodel", mem_valid, 1'b0);

    // Overflow trap capture and EPC retention
    ex_valid = 1'b1; ex_overflow = 1'b1; ex_signed_op = 1'b1; ex_regwrite = 1'b1; ex_pc = 32'h40;
    tick();
    chk("trap_regwrite", mem_regwrite, TRAP_EN ? 1'b0 : 1'b1);
    chk("trap_ovf", mem_overflow, 1'b1);
    chk("trap_exc", {exc_valid, exc_epc}, TRAP_EN ? {1'b1, 32'h40} : {1'b0, RST_EPC});
    ex_pc = 32'h44;
    tick();
    chk("trap_keep_epc", exc_epc, TRAP_EN ? 32'h40 : RST_EPC);
    ex_valid = 1'b0; exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("trap_ack", exc_valid, 1'b0);
    ex_valid = 1'b1; ex_pc = 32'h50;
    tick();
    exc_ack = 1'b1; ex_pc = 32'h54;
    tick();
    idle_inputs();
    chk("trap_ack_new", {exc_valid, exc_epc}, TRAP_EN ? {1'b1, 32'h54} : {1'b0, RST_EPC});
    exc_ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    // Asynchronous reset while in SKID
    mem_ready = 1'b0;
    push(32'hD0); push(32'hD1);
    ex_valid = 1'b0;
    #1; nRST = 1'b0; #1;
    chk("arst_valid", mem_valid, 1'b0);
    chk("arst_word", {mem_aluout, mem_pc, mem_store, mem_rd, mem_regwrite}, '0);
    chk("arst_ready", ex_ready, 1'b0);
    @(posedge CLK); #1; nRST = 1'b1; mem_ready = 1'b1;
    tick();
    chk("arst_rel_ready", ex_ready, 1'b1);
    chk("arst_rel_valid", mem_valid, 1'b0);

    // Randomized traffic checked continuously by the model
    for (int i = 0; i < 3000; i++) begin
      flush        = ($urandom_range(0, 31) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      ex_aluout    = $urandom;
      ex_pc        = $urandom;
      ex_store     = $urandom;
      ex_rd        = 5'($urandom);
      {ex_zero, ex_negative} = 2'($urandom);
      ex_overflow  = ($urandom_range(0, 5) == 0);
      ex_signed_op = $urandom_range(0, 1);
      {ex_regwrite, ex_dren, ex_dwen} = 3'($urandom);
      exc_ack      = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("final_drain", mem_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
